// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, start-bit qualification, 2-of-3 mid-bit vote,
// registered byte hand-off on a valid/ready handshake with framing and overrun pulses.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] T_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] T_EARLY = CW'(HALF - 1);
  localparam logic [CW-1:0] T_MID   = CW'(HALF);
  localparam logic [CW-1:0] T_VOTE  = CW'(HALF + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic          r_sync1, r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic          r_v0, r_v1;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid, r_ferr, r_ovr, r_busy;

  state_t        w_next_state;
  logic          w_rx, w_vote, w_vote_pt, w_bit_end, w_deliver, w_frame_bad;

  assign w_rx      = r_sync2;
  assign w_vote_pt = (r_timer == T_VOTE);
  assign w_bit_end = (r_timer == T_LAST);
  assign w_vote    = maj3(r_v0, r_v1, w_rx);

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state decode; delivery and framing-error strobes are raised at the stop-bit vote.
  always_comb begin
    w_next_state = r_state;
    w_deliver    = 1'b0;
    w_frame_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) w_next_state = S_START;
        else       w_next_state = S_IDLE;
      end
      S_START: begin
        if (w_vote_pt && w_vote) w_next_state = S_IDLE;
        else if (w_bit_end)      w_next_state = S_DATA;
        else                     w_next_state = S_START;
      end
      S_DATA: begin
        if (w_bit_end && (r_idx == 3'd7)) w_next_state = S_STOP;
        else                              w_next_state = S_DATA;
      end
      S_STOP: begin
        if (w_vote_pt) begin
          if (w_vote) begin
            w_deliver    = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_frame_bad  = 1'b1;
            w_next_state = S_BRK;
          end
        end else begin
          w_next_state = S_STOP;
        end
      end
      S_BRK: begin
        if (w_rx) w_next_state = S_IDLE;
        else      w_next_state = S_BRK;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register with busy flag registered from the same next-state value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
    end
  end

  // Bit timer: held at zero while idle or in break so START always begins at count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if ((r_state == S_IDLE) || (r_state == S_BRK)) begin
      r_timer <= '0;
    end else if (w_bit_end) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + CW'(1);
    end
  end

  // Bit index and the two early vote samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= 3'd0;
      r_v0  <= 1'b1;
      r_v1  <= 1'b1;
    end else begin
      if ((r_state == S_START) && w_bit_end) begin
        r_idx <= 3'd0;
      end else if ((r_state == S_DATA) && w_bit_end && (r_idx != 3'd7)) begin
        r_idx <= r_idx + 3'd1;
      end else begin
        r_idx <= r_idx;
      end
      if (r_timer == T_EARLY) r_v0 <= w_rx;
      else                    r_v0 <= r_v0;
      if (r_timer == T_MID)   r_v1 <= w_rx;
      else                    r_v1 <= r_v1;
    end
  end

  // LSB-first shift register: each voted bit enters at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= 8'h00;
    end else if ((r_state == S_DATA) && w_vote_pt) begin
      r_shift <= {w_vote, r_shift[7:1]};
    end else begin
      r_shift <= r_shift;
    end
  end

  // Holding register: a consume in the same cycle frees the slot for a new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_frame_bad;
      r_ovr  <= w_deliver & r_valid & ~ready_i;
      if (w_deliver && (!r_valid || ready_i)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_data  <= r_data;
        r_valid <= 1'b0;
      end else begin
        r_data  <= r_data;
        r_valid <= r_valid;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_ferr;
  assign overrun_o   = r_ovr;
  assign busy_o      = r_busy;

endmodule
